// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Multi-button front end. Each button is sampled on a prescaled
//               tick through a 3-state debounce FSM (IDLE/ARM/HELD). A press
//               (ARM->HELD) queues a pending event, and pending events are
//               handed to one consumer round-robin over valid/ready.
//               Optional macro BTN_AUTOREPEAT_EN adds per-button auto-repeat
//               events every REPEAT_TICKS ticks while a button stays HELD.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int REPEAT_TICKS = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_BTN-1:0]           btn_raw,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [$clog2(N_BTN)-1:0]   evt_id,
  output logic                       evt_overrun,
  output logic [N_BTN-1:0]           held
);

  localparam int ID_W = $clog2(N_BTN);
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [PS_W-1:0]  prescale;
  logic             tick;
  logic [N_BTN-1:0] enter_held;
  logic [N_BTN-1:0] rpt_fire;
  logic [N_BTN-1:0] evt_src;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] drop;
  logic [ID_W-1:0]  rr_last;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             load;
  int               idx;

  // Single-cycle sample strobe at the last count of the prescaler.
  assign tick = (prescale == PS_W'(TICK_DIV - 1));

  // Prescaler: free-running 0..TICK_DIV-1 counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + PS_W'(1);
    end
  end

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic [1:0] state;

      // Debounce FSM: two consecutive high samples are needed to reach HELD.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= ST_IDLE;
        end else if (tick) begin
          case (state)
            ST_IDLE: state <= btn_raw[i] ? ST_ARM  : ST_IDLE;
            ST_ARM:  state <= btn_raw[i] ? ST_HELD : ST_IDLE;
            ST_HELD: state <= btn_raw[i] ? ST_HELD : ST_IDLE;
            default: state <= ST_IDLE;
          endcase
        end
      end

      assign held[i]       = (state == ST_HELD);
      assign enter_held[i] = tick && (state == ST_ARM) && btn_raw[i];

`ifdef BTN_AUTOREPEAT_EN
      localparam int RP_W = $clog2(REPEAT_TICKS);
      logic [RP_W-1:0] rpt_cnt;
      logic            rpt_step;

      // A repeat step is a tick on which the button remains HELD.
      assign rpt_step    = tick && (state == ST_HELD) && btn_raw[i];
      assign rpt_fire[i] = rpt_step && (rpt_cnt == RP_W'(REPEAT_TICKS - 1));

      // Repeat counter: restarts on HELD entry, wraps when it fires.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rpt_cnt <= '0;
        end else if (enter_held[i]) begin
          rpt_cnt <= '0;
        end else if (rpt_step) begin
          if (rpt_cnt == RP_W'(REPEAT_TICKS - 1)) begin
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RP_W'(1);
          end
        end
      end
`else
      assign rpt_fire[i] = 1'b0;
`endif
    end
  endgenerate

  assign evt_src = enter_held | rpt_fire;

  // Output slot can take a new event when empty or being drained this cycle.
  assign load = !evt_valid || evt_ready;

  // Round-robin search starting just after the last granted button.
  always_comb begin
    found  = 1'b0;
    winner = rr_last;
    idx    = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(rr_last) + k) % N_BTN;
      if (!found && pending[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign grant = (load && found) ? (N_BTN'(1) << winner) : '0;
  // A bit leaving through the grant this edge is free again, so a
  // simultaneous new event for it is kept rather than dropped.
  assign drop  = evt_src & pending & ~grant;

  // Pending set, output slot and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_overrun <= 1'b0;
      rr_last     <= ID_W'(N_BTN - 1);
    end else begin
      pending     <= (pending & ~grant) | evt_src;
      evt_overrun <= |drop;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id  <= winner;
          rr_last <= winner;
        end
      end
    end
  end

endmodule
`default_nettype wire
